// File: rtl/game_state_ctrl.sv
// Bomberman game-phase sequencer: lives, death animation, respawn grace, win/over.
// Optional: define GAME_STATE_FLASH_EN to blink the screen during respawn grace.
module game_state_ctrl #(
  parameter int LIVES        = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int GRACE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       v_sync,
  input  logic       start,
  input  logic       enemy_hit,
  input  logic       blast_hit,
  input  logic       all_killed,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic       respawn,
  output logic       enemy_run,
  output logic       input_en,
  output logic [1:0] overlay
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_DYING   = 3'd2,
    S_RESPAWN = 3'd3,
    S_WIN     = 3'd4,
    S_OVER    = 3'd5
  } state_e;

  localparam logic [7:0] DEATH_N = 8'(DEATH_FRAMES);
  localparam logic [7:0] GRACE_N = 8'(GRACE_FRAMES);

  logic       vs_s1_q, vs_s2_q, vs_dly_q;
  logic       tick;
  state_e     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] fcnt_q, fcnt_d, fcnt_inc;
  logic       respawn_q, respawn_d;
  logic       enemy_run_q, enemy_run_d;
  logic       input_en_q, input_en_d;
  logic [1:0] overlay_q, overlay_d;

  // Falling edge of the synchronised vSync marks one frame
  assign tick = vs_dly_q & ~vs_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_s1_q  <= 1'b1;
      vs_s2_q  <= 1'b1;
      vs_dly_q <= 1'b1;
    end else begin
      vs_s1_q  <= v_sync;
      vs_s2_q  <= vs_s1_q;
      vs_dly_q <= vs_s2_q;
    end
  end

  always_comb begin
    fcnt_inc = fcnt_q;
    if (tick && fcnt_q != 8'hff) begin
      fcnt_inc = fcnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    respawn_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (enemy_hit || blast_hit) state_d = S_DYING;
        else if (all_killed)        state_d = S_WIN;
      end
      S_DYING: begin
        if (tick && fcnt_inc == DEATH_N) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            lives_d   = lives_q - 2'd1;
            respawn_d = 1'b1;
            state_d   = S_RESPAWN;
          end
        end
      end
      S_RESPAWN: begin
        if (all_killed)                         state_d = S_WIN;
        else if (tick && fcnt_inc == GRACE_N) state_d = S_PLAY;
      end
      S_WIN:  state_d = S_WIN;
      S_OVER: state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase
  end

  assign fcnt_d = (state_d != state_q) ? 8'd0 : fcnt_inc;

  // Outputs decode the next state so they line up with the state register
  always_comb begin
    enemy_run_d = 1'b0;
    input_en_d  = 1'b0;
    overlay_d   = 2'b00;
    unique case (state_d)
      S_IDLE: input_en_d = 1'b1;
      S_PLAY: begin
        enemy_run_d = 1'b1;
        input_en_d  = 1'b1;
      end
      S_DYING: overlay_d = 2'b01;
      S_RESPAWN: begin
        enemy_run_d = 1'b1;
        input_en_d  = 1'b1;
`ifdef GAME_STATE_FLASH_EN
        overlay_d   = fcnt_d[3] ? 2'b11 : 2'b00;
`else
        overlay_d   = 2'b00;
`endif
      end
      S_WIN:  overlay_d = 2'b10;
      S_OVER: overlay_d = 2'b01;
      default: input_en_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lives_q     <= 2'(LIVES);
      fcnt_q      <= 8'd0;
      respawn_q   <= 1'b0;
      enemy_run_q <= 1'b0;
      input_en_q  <= 1'b1;
      overlay_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      fcnt_q      <= fcnt_d;
      respawn_q   <= respawn_d;
      enemy_run_q <= enemy_run_d;
      input_en_q  <= input_en_d;
      overlay_q   <= overlay_d;
    end
  end

  assign state     = state_q;
  assign lives     = lives_q;
  assign respawn   = respawn_q;
  assign enemy_run = enemy_run_q;
  assign input_en  = input_en_q;
  assign overlay   = overlay_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed game flow plus random play
// against a frame-level model of the game rules.
module tb_game_state_ctrl;

  localparam int LV = 3;
  localparam int DF = 60;
  localparam int GF = 120;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       v_sync = 1'b1;
  logic       start = 1'b0;
  logic       enemy_hit = 1'b0;
  logic       blast_hit = 1'b0;
  logic       all_killed = 1'b0;
  logic [2:0] state;
  logic [1:0] lives;
  logic       respawn;
  logic       enemy_run;
  logic       input_en;
  logic [1:0] overlay;

  int n_chk = 0;
  int n_bad = 0;
  int rs_seen = 0;

  int m_st = 0;
  int m_lives = LV;
  int m_cnt = 0;
  int m_rs = 0;

  game_state_ctrl #(
    .LIVES(LV), .DEATH_FRAMES(DF), .GRACE_FRAMES(GF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .v_sync(v_sync),
    .start(start), .enemy_hit(enemy_hit),
    .blast_hit(blast_hit), .all_killed(all_killed),
    .state(state), .lives(lives), .respawn(respawn),
    .enemy_run(enemy_run), .input_en(input_en),
    .overlay(overlay)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && respawn === 1'b1) begin
      rs_seen++;
      chk("rs_state", 32'(state), 32'd3);
    end
  end

  task automatic go(input int s);
    if (s != m_st) m_cnt = 0;
    m_st = s;
  endtask

  task automatic model_pulse(input bit s, input bit eh,
                             input bit bh, input bit ak);
    case (m_st)
      0: if (s) go(1);
      1: if (eh || bh) go(2); else if (ak) go(4);
      3: if (ak) go(4);
      default: ;
    endcase
  endtask

  task automatic model_frame();
    if (m_cnt < 255) m_cnt++;
    if (m_st == 2 && m_cnt == DF) begin
      if (m_lives == 1) begin
        m_lives = 0;
        go(5);
      end else begin
        m_lives--;
        m_rs++;
        go(3);
      end
    end else if (m_st == 3 && m_cnt == GF) begin
      go(1);
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] ov;
    ov = 2'b00;
    if (m_st == 2 || m_st == 5) ov = 2'b01;
    if (m_st == 4) ov = 2'b10;
`ifdef GAME_STATE_FLASH_EN
    if (m_st == 3 && m_cnt[3]) ov = 2'b11;
`endif
    chk({tag, ".state"}, 32'(state), 32'(m_st));
    chk({tag, ".lives"}, 32'(lives), 32'(m_lives));
    chk({tag, ".run"}, 32'(enemy_run),
        32'(m_st == 1 || m_st == 3));
    chk({tag, ".inen"}, 32'(input_en),
        32'(m_st <= 1 || m_st == 3));
    chk({tag, ".ovl"}, 32'(overlay), 32'(ov));
    chk({tag, ".rs"}, 32'(rs_seen), 32'(m_rs));
  endtask

  // Async assert between edges; outputs must clear without a clock
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    m_st = 0; m_lives = LV; m_cnt = 0;
    check_all({tag, ".rst"});
    chk({tag, ".rst_rsp"}, 32'(respawn), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input string tag, input bit s, input bit eh,
                       input bit bh, input bit ak);
    start = s; enemy_hit = eh; blast_hit = bh; all_killed = ak;
    @(negedge clk);
    start = 0; enemy_hit = 0; blast_hit = 0; all_killed = 0;
    @(negedge clk);
    model_pulse(s, eh, bh, ak);
    check_all(tag);
  endtask

  task automatic frame(input string tag);
    v_sync = 1'b0;
    @(negedge clk);
    v_sync = 1'b1;
    repeat (5) @(negedge clk);
    model_frame();
    check_all(tag);
  endtask

  task automatic frames(input string tag, input int n);
    for (int i = 0; i < n; i++) frame(tag);
  endtask

  initial begin
    @(negedge clk);
    do_reset("init");

    pulse("start", 1, 0, 0, 0);
    pulse("hit1", 0, 1, 0, 0);
    frames("dying1", DF);
    chk("after1.lives", 32'(lives), 32'd2);
    frames("grace1", 10);
    pulse("rsp_hit", 0, 1, 1, 0);
    frames("grace1b", GF - 10);
    chk("after1.play", 32'(state), 32'd1);

    pulse("hit_ak", 0, 1, 0, 1);
    chk("hit_ak.dying", 32'(state), 32'd2);
    frames("dying2", DF);
    frames("grace2", GF);
    pulse("hit3", 0, 0, 1, 0);
    frames("dying3", DF);
    chk("over.state", 32'(state), 32'd5);
    chk("over.rs", 32'(rs_seen), 32'd2);
    pulse("over_start", 1, 1, 0, 1);

    do_reset("r2");
    pulse("start2", 1, 0, 0, 0);
    pulse("win", 0, 0, 0, 1);
    pulse("win_hit", 0, 1, 1, 0);
    frames("win_f", 3);

    do_reset("r3");
    pulse("start3", 1, 0, 0, 0);
    pulse("hit4", 0, 1, 0, 0);
    frames("dying4", DF / 2);
    do_reset("mid_dying");
    frames("idle_f", 3);

    for (int g = 0; g < 6; g++) begin
      do_reset("rnd_rst");
      for (int s = 0; s < 300; s++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 5)       pulse("r_start", 1, 0, 0, 0);
        else if (r < 8)  pulse("r_eh", 0, 1, 0, 0);
        else if (r < 10) pulse("r_bh", 0, 0, 1, 0);
        else if (r < 11) pulse("r_ak", 0, 0, 0, 1);
        else if (r < 12) pulse("r_hak", 0, 1, 0, 1);
        else             frame("r_frame");
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
